// File: rtl/lambda_rr_sched.sv
// Frame-locked round-robin scheduler that shares one lambda = mag - rho*phi datapath
// between NUM_REQ requesters. Results pass through a one-deep output register.
module lambda_rr_sched #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned MAX_BEATS = 256,
    parameter logic [7:0]  RHO_RST   = 8'h40
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ-1:0]    req_last_i,
    input  logic [NUM_REQ*16-1:0] req_mag_i,
    input  logic [NUM_REQ*16-1:0] req_phi_i,
    input  logic                  cfg_we_i,
    input  logic [1:0]            cfg_sel_i,
    input  logic [7:0]            cfg_rho_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [15:0]           out_lambda_o,
    output logic [1:0]            out_id_o,
    output logic                  out_last_o,
    output logic                  err_overrun_o
);

    localparam int unsigned CntW = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        rr_q, rr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [7:0]        active_rho_q, active_rho_d;
    logic [7:0]        rho_q [4];

    logic              out_valid_q, out_valid_d;
    logic [15:0]       out_lambda_q, out_lambda_d;
    logic [1:0]        out_id_q, out_id_d;
    logic              out_last_q, out_last_d;
    logic              err_q, err_d;

    // Pad per-requester buses to four lanes so a 2-bit index is always in range.
    logic [3:0]        valid_pad, last_pad, ready_pad;
    logic [63:0]       mag_pad, phi_pad;
    logic [15:0]       mag_sel, phi_sel;
    logic signed [23:0] prod;
    logic [15:0]       lambda;
    logic              xfer, forced;

    assign valid_pad = 4'(req_valid_i);
    assign last_pad  = 4'(req_last_i);
    assign mag_pad   = 64'(req_mag_i);
    assign phi_pad   = 64'(req_phi_i);
    assign mag_sel   = mag_pad[{grant_q, 4'b0000} +: 16];
    assign phi_sel   = phi_pad[{grant_q, 4'b0000} +: 16];

    // Q1.7 * Q6.10 -> Q7.17; bits [22:7] are the Q6.10 product, wrapping on overflow.
    assign prod   = $signed(active_rho_q) * $signed(phi_sel);
    assign lambda = mag_sel - 16'(prod >>> 7);

    assign req_ready_o = ready_pad[NUM_REQ-1:0];

    always_comb begin
        logic       found;
        logic [1:0] cand;
        state_d      = state_q;
        grant_d      = grant_q;
        rr_d         = rr_q;
        cnt_d        = cnt_q;
        active_rho_d = active_rho_q;
        ready_pad    = '0;
        xfer         = 1'b0;
        forced       = 1'b0;
        found        = 1'b0;
        cand         = '0;

        unique case (state_q)
            StIdle: begin
                for (int i = 0; i < int'(NUM_REQ); i++) begin
                    cand = 2'((int'(rr_q) + i) % int'(NUM_REQ));
                    if (!found && valid_pad[cand]) begin
                        found   = 1'b1;
                        grant_d = cand;
                    end
                end
                if (found) begin
                    active_rho_d = rho_q[grant_d];
                    state_d      = StBusy;
                end
            end
            StBusy: begin
                ready_pad[grant_q] = !out_valid_q || out_ready_i;
                xfer = ready_pad[grant_q] && valid_pad[grant_q];
                if (xfer) begin
                    cnt_d = cnt_q + CntW'(1);
                    if (last_pad[grant_q] || (cnt_q == CntW'(MAX_BEATS - 1))) begin
                        forced  = !last_pad[grant_q];
                        state_d = StIdle;
                        rr_d    = (grant_q == 2'(NUM_REQ - 1)) ? 2'd0 : grant_q + 2'd1;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_lambda_d = out_lambda_q;
        out_id_d     = out_id_q;
        out_last_d   = out_last_q;
        err_d        = err_q | forced;
        if (xfer) begin
            out_valid_d  = 1'b1;
            out_lambda_d = lambda;
            out_id_d     = grant_q;
            out_last_d   = last_pad[grant_q] | forced;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            rr_q         <= '0;
            cnt_q        <= '0;
            active_rho_q <= RHO_RST;
            out_valid_q  <= 1'b0;
            out_lambda_q <= '0;
            out_id_q     <= '0;
            out_last_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_q         <= rr_d;
            cnt_q        <= cnt_d;
            active_rho_q <= active_rho_d;
            out_valid_q  <= out_valid_d;
            out_lambda_q <= out_lambda_d;
            out_id_q     <= out_id_d;
            out_last_q   <= out_last_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                rho_q[i] <= RHO_RST;
            end
        end else if (cfg_we_i && ({1'b0, cfg_sel_i} < 3'(NUM_REQ))) begin
            rho_q[cfg_sel_i] <= cfg_rho_i;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_lambda_o  = out_lambda_q;
    assign out_id_o      = out_id_q;
    assign out_last_o    = out_last_q;
    assign err_overrun_o = err_q;

endmodule

// File: doc/lambda_rr_sched.md
Name: lambda_rr_sched

Overview:
- Shares one rho*phi subtract datapath between NUM_REQ symbol-stream requesters, e.g. detector layers producing LLRs.
- Datapath: lambda = mag - rho*phi, with rho in Q1.7, phi/mag/lambda in Q6.10.
- Arbitration is frame-locked round-robin. Each requester has its own rho held in a config register.
- A one-deep output register carries requester id and frame-last tags.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- MAX_BEATS, 256, beat limit per frame before forced termination.
- RHO_RST, 8'h40, reset value of every rho config register (0.5 in Q1.7).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_ready  out  NUM_REQ  per-requester beat accept.
- req_last  in  NUM_REQ  marks the final beat of a frame.
- req_mag  in  NUM_REQ*16  mag_t per requester, Q6.10.
- req_phi  in  NUM_REQ*16  phi_t per requester, Q6.10.
- cfg_we  in  1  rho register write strobe.
- cfg_sel  in  2  rho register index.
- cfg_rho  in  8  rho_t value, Q1.7.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_lambda  out  16  lambda_t, Q6.10.
- out_id  out  2  requester index of the result.
- out_last  out  1  frame end; set by req_last or by forced termination.
- err_overrun  out  1  sticky flag; set on forced termination.

Behaviour:
- Reset values: req_ready=0, out_valid=0, out_lambda=0, out_id=0, out_last=0, err_overrun=0, state=IDLE, rr pointer=0, beat counter=0, all rho regs=RHO_RST.
- Reset is asynchronous and may assert mid-frame. The frame in flight is discarded and the output register is cleared.

State machine:
- IDLE: scan requests starting at the rr pointer, wrapping. The first index with req_valid=1 becomes the grant. Latch rho[grant] into active_rho and go to BUSY. The cycle that grants does not accept a beat.
- BUSY: only req_ready[grant] may be 1. It is 1 when out_valid=0 or out_ready=1. A beat transfers when req_valid & req_ready for the granted index.
- Leaving BUSY: on transfer of a beat with req_last=1, or when the beat counter reaches MAX_BEATS-1 on transfer, go to IDLE. Set rr pointer = grant+1 mod NUM_REQ and clear the beat counter.

Forced termination (MAX_BEATS beats with no req_last):
- That beat is emitted with out_last=1 and err_overrun is set.
- The requester's remaining beats are arbitrated as a new frame later.
- err_overrun is cleared only by rst.

Config writes:
- cfg_we writes rho[cfg_sel] on the clock edge.
- active_rho does not change mid-frame. A write to the granted index takes effect at that requester's next grant.
- cfg_sel >= NUM_REQ: write ignored.

Datapath (1-cycle latency, beat to out_valid):
- prod = signed(active_rho) * signed(mag-side phi), 24 bits, Q7.17.
- Arithmetic shift right by 7.
- Keep the low 16 bits (wrap, no saturation).
- out_lambda = mag - that 16-bit value, 16-bit wrap.
- out_id = grant. out_last is registered with the result.

Output register:
- Holds its contents while out_valid=1 and out_ready=0.
- A new beat loads in the same cycle the old result is consumed, giving full throughput of 1 beat/cycle.
- out_valid falls only when the result is consumed and no new beat is loaded.

Other rules:
- Requesters that are not granted see req_ready=0. They must hold req_valid and their data.
- A requester dropping req_valid mid-frame keeps the grant; the frame stays locked until last or MAX_BEATS.

Test Plan:
1. Arithmetic: rho=0x40, mag=0x0400, phi=0x0800 -> out_lambda=0x0000. rho=0x80, mag=0x0400, phi=0x0400 -> out_lambda=0x0800.
2. Wrap: rho=0x80, mag=0x7FFF, phi=0x7FFF -> out_lambda=0xFFFE, no saturation.
3. Round-robin: both requesters valid continuously, 3-beat frames, out_ready=1.
   - out_id sequence 0,0,0,1,1,1,0,...
   - out_last on every 3rd beat.
   - one idle grant cycle between frames.
4. Backpressure: out_ready=0 for 4 cycles mid-frame.
   - out_lambda and out_id stable; req_ready[grant]=0.
   - Beats resume with none lost or duplicated.
5. Config timing: write cfg_sel=0, cfg_rho=0x00 during requester 0's frame (mag=0x0400, phi=0x0400).
   - Current frame results stay 0x0200 (rho=0x40).
   - Next frame from requester 0 gives 0x0400.
6. Overrun and reset: MAX_BEATS=4, requester streams 6 beats with no last.
   - 4th beat has out_last=1; err_overrun=1; grant passes to the other requester if it is valid.
   - Then assert rst mid-frame: all outputs zero at once, err_overrun=0, rho=0x40.
